// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the waveform capture engine.
// Optional build macro used by the engine: WAVE_CAPTURE_DECIMATE_EN.
package wave_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  // Threshold crossing between two consecutive samples, given each one's
  // comparison against the level (ge = sample >= level).
  function automatic logic edge_cross(input logic edge_sel, input logic prev_ge,
                                      input logic cur_ge);
    if (edge_sel == TRIG_RISING) return !prev_ge && cur_ge;
    else                         return prev_ge && !cur_ge;
  endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Simple dual-port capture memory: one write port, one read port with a
// registered (1-cycle) output that holds its value while re is low.
module wave_capture_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port; output held when no read is issued
  always_ff @(posedge clk) begin
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/wave_capture_buffer.sv
// Waveform capture engine: circular capture with pre-trigger depth and an
// edge/forced trigger, then a valid/ready readout of the DEPTH-word window.
// Build macro WAVE_CAPTURE_DECIMATE_EN enables the decim input (keep one of
// every decim+1 valid samples); without it every valid sample is kept.
module wave_capture_buffer
  import wave_capture_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int TRIG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WORD_W = NUM_CH * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [TRIG_W-1:0] trig_ch,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [7:0]        decim,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic [2:0]        state
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, cnt_q, trig_addr_q, pretrig_q;
  logic [TRIG_W-1:0] trig_ch_q;
  logic              trig_edge_q;
  logic [DATA_W-1:0] level_q, prev_q;
  logic              prev_vld_q, force_pend_q, triggered_q;

  logic [ADDR_W-1:0] issue_cnt_q;
  logic              issue_done_q, ram_vld_q, ram_last_q;
  logic              rd_valid_q, rd_last_q;
  logic [WORD_W-1:0] rd_data_q, ram_rdata;

  logic              capturing, dec_ok, acc, arm_go;
  logic [DATA_W-1:0] cur;
  logic              edge_hit, trig_hit, fill_done, post_done;
  logic [ADDR_W-1:0] cnt_inc, post_need, rd_addr;
  logic              out_free, issue;

  assign capturing = (state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign arm_go    = (state_q == ST_IDLE) && arm && !abort;

`ifdef WAVE_CAPTURE_DECIMATE_EN
  logic [7:0] decim_q, dcnt_q;

  assign dec_ok = (dcnt_q == 8'd0);

  // Decimation counter: restarts on arm so the first valid sample is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= 8'd0;
      dcnt_q  <= 8'd0;
    end else if (arm_go) begin
      decim_q <= decim;
      dcnt_q  <= 8'd0;
    end else if (sample_valid && capturing && !abort) begin
      dcnt_q <= (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
    end
  end
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign dec_ok       = 1'b1;
`endif

  // Abort suppresses the write so it also wins over a same-cycle trigger
  assign acc = sample_valid && capturing && dec_ok && !abort;

  // Select the trigger channel from the incoming sample word
  always_comb begin
    cur = sample_in[DATA_W-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (trig_ch_q == TRIG_W'(c)) cur = sample_in[c*DATA_W +: DATA_W];
    end
  end

  assign edge_hit  = prev_vld_q && edge_cross(trig_edge_q, prev_q >= level_q, cur >= level_q);
  assign trig_hit  = (state_q == ST_ARMED) && acc && (edge_hit || force_trig || force_pend_q);
  assign cnt_inc   = cnt_q + 1'b1;
  assign fill_done = (cnt_inc == pretrig_q);
  assign post_need = ADDR_LAST - pretrig_q;
  assign post_done = (cnt_inc == post_need);

  // Readout pipeline: RAM output stage feeds the output register
  assign out_free = !rd_valid_q || rd_ready;
  assign issue    = (state_q == ST_READ) && !issue_done_q && (!ram_vld_q || out_free);
  assign rd_addr  = trig_addr_q - pretrig_q + issue_cnt_q;

  wave_capture_ram #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (acc),
    .waddr(wr_ptr_q),
    .wdata(sample_in),
    .re   (issue),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (arm) state_d = (pretrig == '0) ? ST_ARMED : ST_FILL;
        ST_FILL:  if (acc && fill_done) state_d = ST_ARMED;
        ST_ARMED: if (trig_hit) state_d = (post_need == '0) ? ST_READ : ST_POST;
        ST_POST:  if (acc && post_done) state_d = ST_READ;
        ST_READ:  if (rd_valid_q && rd_ready && rd_last_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy  = (state_q != ST_IDLE);
    state = state_q;
  end

  // Capture control: configuration latch, write pointer, trigger tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      trig_addr_q  <= '0;
      pretrig_q    <= '0;
      trig_ch_q    <= '0;
      trig_edge_q  <= TRIG_RISING;
      level_q      <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
      triggered_q  <= 1'b0;
    end else if (arm_go) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pretrig_q    <= pretrig;
      trig_ch_q    <= trig_ch;
      trig_edge_q  <= trig_edge;
      level_q      <= trig_level;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
      triggered_q  <= 1'b0;
    end else begin
      if (acc) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        prev_q     <= cur;
        prev_vld_q <= 1'b1;
      end
      case (state_q)
        ST_FILL: if (acc) cnt_q <= fill_done ? '0 : cnt_inc;
        ST_ARMED: begin
          if (trig_hit) begin
            trig_addr_q  <= wr_ptr_q;
            triggered_q  <= 1'b1;
            cnt_q        <= '0;
            force_pend_q <= 1'b0;
          end else if (force_trig && !abort) begin
            force_pend_q <= 1'b1;
          end
        end
        ST_POST: if (acc) cnt_q <= cnt_inc;
        default: ;
      endcase
      if (abort) force_pend_q <= 1'b0;
    end
  end

  // Readout: address issue, RAM-stage valid, and stall-safe output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else if (abort || state_q != ST_READ) begin
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      if (issue) begin
        issue_cnt_q  <= issue_cnt_q + 1'b1;
        issue_done_q <= (issue_cnt_q == ADDR_LAST);
        ram_last_q   <= (issue_cnt_q == ADDR_LAST);
        ram_vld_q    <= 1'b1;
      end else if (out_free) begin
        ram_vld_q <= 1'b0;
      end
      if (out_free) begin
        rd_valid_q <= ram_vld_q;
        rd_last_q  <= ram_last_q;
        if (ram_vld_q) rd_data_q <= ram_rdata;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed scoreboard bench for wave_capture_buffer (DEPTH=16, 2 x 12-bit).
module tb_wave_capture_buffer;

  localparam int DW   = 12;
  localparam int NC   = 2;
  localparam int DP   = 16;
  localparam int HLEN = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          force_trig = 1'b0;
  logic          trig_ch = 1'b0;
  logic          trig_edge = 1'b0;
  logic [11:0]   trig_level = '0;
  logic [3:0]    pretrig = '0;
  logic [7:0]    decim = '0;
  logic [23:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic          busy;
  logic          triggered;
  logic [2:0]    st;

  int            vecs = 0;
  int            errs = 0;
  logic [23:0]   exp_q[$];
  logic [11:0]   raw0[HLEN];
  logic [11:0]   raw1[HLEN];

  wave_capture_buffer #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trig_ch(trig_ch),
    .trig_edge(trig_edge), .trig_level(trig_level), .pretrig(pretrig), .decim(decim),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .triggered(triggered), .state(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimate the raw stream, locate the trigger, push window
  task automatic model_push(input int pre, input bit ch, input bit edg,
                            input logic [11:0] lvl, input int dec, input bit frc);
    logic [11:0] a0[$];
    logic [11:0] a1[$];
    logic [11:0] pv, cv;
    int k;
    for (int i = 0; i < HLEN; i++) begin
      if (i % (dec + 1) == 0) begin
        a0.push_back(raw0[i]);
        a1.push_back(raw1[i]);
      end
    end
    k = -1;
    if (frc) k = pre;
    else begin
      for (int j = (pre > 1 ? pre : 1); j < a0.size(); j++) begin
        pv = ch ? a1[j-1] : a0[j-1];
        cv = ch ? a1[j] : a0[j];
        if (k < 0 && !edg && pv < lvl && cv >= lvl) k = j;
        if (k < 0 && edg && pv >= lvl && cv < lvl) k = j;
      end
    end
    if (k < 0 || k - pre + DP > a0.size()) begin
      vecs++; errs++;
      $error("FAIL model_window: observed k=%0d expected a usable trigger", k);
    end else begin
      for (int j = 0; j < DP; j++) exp_q.push_back({a1[k-pre+j], a0[k-pre+j]});
    end
  endtask

  // Arm the DUT at a negedge; returns at the following negedge
  task automatic arm_dut(input int pre, input bit ch, input bit edg,
                         input logic [11:0] lvl, input int dec);
    @(negedge clk);
    pretrig = 4'(pre); trig_ch = ch; trig_edge = edg; trig_level = lvl; decim = 8'(dec);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("arm_state", st, (pre == 0) ? 3'd2 : 3'd1);
    check("arm_busy", busy, 1'b1);
    check("arm_trig_clr", triggered, 1'b0);
  endtask

  // Drive raw samples one per cycle until READ; optionally force-trigger in ARMED
  task automatic feed(input bit frc);
    int i = 0;
    bit forced = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (st == 3'd4) break;
      force_trig = 1'b0;
      if (frc && !forced && st == 3'd2) begin
        force_trig = 1'b1; sample_valid = 1'b0; forced = 1;
      end else if (i < HLEN) begin
        sample_in = {raw1[i], raw0[i]}; sample_valid = 1'b1; i++;
      end else sample_valid = 1'b0;
      @(negedge clk);
    end
    sample_valid = 1'b0; force_trig = 1'b0;
    check("reach_read", st, 3'd4);
    check("lat_t0", rd_valid, 1'b0);
    @(negedge clk);
    check("lat_t1", rd_valid, 1'b0);
    @(negedge clk);
    check("lat_t2", rd_valid, 1'b1);
  endtask

  // Drain the readout window against the scoreboard
  task automatic collect(input bit toggle);
    int got = 0;
    bit held = 0;
    bit ph = 1;
    logic [23:0] hd, e;
    logic hl;
    for (int cyc = 0; cyc < 200 && got < DP; cyc++) begin
      rd_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (held) begin
        check("stall_valid", rd_valid, 1'b1);
        check("stall_data", rd_data, hd);
        check("stall_last", rd_last, hl);
        held = 0;
      end
      if (!toggle) check("sustain_valid", rd_valid, 1'b1);
      if (rd_valid && rd_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        check($sformatf("word%0d", got), rd_data, e);
        check($sformatf("last%0d", got), rd_last, (got == DP - 1));
        got++;
      end else if (rd_valid) begin
        held = 1; hd = rd_data; hl = rd_last;
      end
      @(negedge clk);
    end
    rd_ready = 1'b1;
    check("word_count", got, DP);
    check("end_state", st, 3'd0);
    check("end_busy", busy, 1'b0);
    check("end_valid", rd_valid, 1'b0);
    check("end_triggered", triggered, 1'b1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic ramp_ch0(input int step);
    for (int i = 0; i < HLEN; i++) begin
      raw0[i] = 12'(step * i);
      raw1[i] = 12'(7 * i + 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", st, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_last", rd_last, 1'b0);
    check("rst_data", rd_data, 24'h0);
    check("rst_trig", triggered, 1'b0);
    rst_n = 1'b1;
    rd_ready = 1'b1;

    // Ch0 ramp, rising at 100, pretrig 4
    ramp_ch0(10);
    model_push(4, 1'b0, 1'b0, 12'd100, 0, 1'b0);
    arm_dut(4, 1'b0, 1'b0, 12'd100, 0);
    feed(1'b0);
    collect(1'b0);

    // Ch1 descending, falling at 250, pretrig 0
    for (int i = 0; i < HLEN; i++) begin
      raw0[i] = 12'(i);
      raw1[i] = 12'(300 - 10 * i);
    end
    model_push(0, 1'b1, 1'b1, 12'd250, 0, 1'b0);
    check("s2_word0_model", exp_q[0][23:12], 12'd240);
    arm_dut(0, 1'b1, 1'b1, 12'd250, 0);
    feed(1'b0);
    collect(1'b0);

    // Constant data, forced trigger
    for (int i = 0; i < HLEN; i++) begin
      raw0[i] = 12'd5;
      raw1[i] = 12'(i + 100);
    end
    model_push(2, 1'b0, 1'b0, 12'd100, 0, 1'b1);
    arm_dut(2, 1'b0, 1'b0, 12'd100, 0);
    feed(1'b1);
    collect(1'b0);

    // Scenario 1 again with rd_ready toggling
    ramp_ch0(10);
    model_push(4, 1'b0, 1'b0, 12'd100, 0, 1'b0);
    arm_dut(4, 1'b0, 1'b0, 12'd100, 0);
    feed(1'b0);
    collect(1'b1);

    // Abort during POST, then a clean re-capture
    arm_dut(4, 1'b0, 1'b0, 12'd100, 0);
    for (int i = 0; i < 40 && st != 3'd3; i++) begin
      sample_in = {raw1[i], raw0[i]}; sample_valid = 1'b1;
      @(negedge clk);
    end
    check("abort_in_post", st, 3'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; sample_valid = 1'b0;
    check("abort_state", st, 3'd0);
    check("abort_busy", busy, 1'b0);
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        if (rd_valid) seen++;
        @(negedge clk);
      end
      check("abort_no_valid", seen, 0);
    end
    model_push(4, 1'b0, 1'b0, 12'd100, 0, 1'b0);
    arm_dut(4, 1'b0, 1'b0, 12'd100, 0);
    feed(1'b0);
    collect(1'b0);

`ifdef WAVE_CAPTURE_DECIMATE_EN
    // Decimation by 3 on a unit ramp
    ramp_ch0(1);
    model_push(4, 1'b0, 1'b0, 12'd40, 2, 1'b0);
    check("dec_step_model", exp_q[1][11:0] - exp_q[0][11:0], 12'd3);
    arm_dut(4, 1'b0, 1'b0, 12'd40, 2);
    feed(1'b0);
    collect(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
